// File: rtl/nes_clk_reset_gen.sv
// Purpose : NES core clock-enable and reset generator. It releases the core reset once PLL lock has been stable long enough.
// Latency : 2-flop lock synchroniser, then LOCK_STABLE_CYCLES of qualification. The first cpu_ce/ppu_ce pulse comes 1 cycle after sys_resetn rises.
// Backpres: none in the default build; with NES_CLK_PAUSE_EN, pause freezes the CE cadence at the CPU-cycle boundary.
//
// Ports:
//   clk        - sole clock (divided PLL output)
//   resetn     - asynchronous active-low reset
//   pll_lock   - PLL lock, asynchronous to clk
//   pause      - freeze request (only when NES_CLK_PAUSE_EN is defined)
//   pause_ack  - core frozen (only when NES_CLK_PAUSE_EN is defined)
//   sys_resetn - registered active-low core reset, high only in S_RUN
//   cpu_ce     - one-cycle CPU clock enable, every CPU_DIV cycles
//   ppu_ce     - one-cycle PPU clock enable, every PPU_DIV cycles
// Optional feature macro: NES_CLK_PAUSE_EN (pause/pause_ack handshake).
module nes_clk_reset_gen #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DIV            = 12,
  parameter int PPU_DIV            = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic pll_lock,
`ifdef NES_CLK_PAUSE_EN
  input  logic pause,
  output logic pause_ack,
`endif
  output logic sys_resetn,
  output logic cpu_ce,
  output logic ppu_ce
);

  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int PW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [SW-1:0] ST_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CPU_DIV - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          lock_meta, lock_s;
  logic [SW-1:0] stable_cnt, stable_next;
  logic [PW-1:0] phase, phase_next;
  logic          run_now;
  logic          ppu_hit;
`ifdef NES_CLK_PAUSE_EN
  logic          freeze;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_WAIT_LOCK;
      stable_cnt <= '0;
      phase      <= '0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_next;
      phase      <= phase_next;
    end
  end

  always_comb begin
    state_next  = state;
    stable_next = stable_cnt;
    phase_next  = '0;
`ifdef NES_CLK_PAUSE_EN
    freeze      = 1'b0;
`endif
    // Losing lock in any state drops everything back to qualification.
    if (!lock_s) begin
      state_next  = S_WAIT_LOCK;
      stable_next = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          state_next  = S_STABLE;
          stable_next = '0;
        end
        S_STABLE: begin
          // The counter saturates at its terminal value instead of wrapping.
          if (stable_cnt == ST_LAST) begin
            state_next = S_RUN;
          end else begin
            stable_next = stable_cnt + SW'(1);
          end
        end
        S_RUN: begin
          if (phase == PH_LAST) begin
`ifdef NES_CLK_PAUSE_EN
            // Park on the last phase so neither enable fires while frozen.
            if (pause) begin
              phase_next = phase;
              freeze     = 1'b1;
            end else begin
              phase_next = '0;
            end
`else
            phase_next = '0;
`endif
          end else begin
            phase_next = phase + PW'(1);
          end
        end
        default: begin
          state_next  = S_WAIT_LOCK;
          stable_next = '0;
        end
      endcase
    end
  end

  // Enables only fire when we stay in S_RUN. This keeps them low on the cycle sys_resetn falls.
  assign run_now = (state == S_RUN) && (state_next == S_RUN);
  assign ppu_hit = ((int'(phase) % PPU_DIV) == 0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sys_resetn <= 1'b0;
      cpu_ce     <= 1'b0;
      ppu_ce     <= 1'b0;
    end else begin
      sys_resetn <= (state_next == S_RUN);
      cpu_ce     <= run_now && (phase == '0);
      ppu_ce     <= run_now && ppu_hit;
    end
  end

`ifdef NES_CLK_PAUSE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pause_ack <= 1'b0;
    end else begin
      pause_ack <= freeze;
    end
  end
`endif

endmodule

// File: tb/tb_nes_clk_reset_gen.sv
// Purpose : Directed bench for nes_clk_reset_gen: lock qualification, CE cadence, lock loss, async reset, and optional pause.
// Latency : Expected edge numbers are hand-derived from the synchroniser depth and qualification length.
// Backpres: n/a; the pause handshake is exercised when NES_CLK_PAUSE_EN is defined.
module tb_nes_clk_reset_gen;

  localparam int LSC = 1024;
  localparam int CPD = 12;
  localparam int PPD = 4;

  logic clk;
  logic resetn;
  logic pll_lock;
  logic sys_resetn;
  logic cpu_ce;
  logic ppu_ce;
`ifdef NES_CLK_PAUSE_EN
  logic pause;
  logic pause_ack;
`endif

  int checks;
  int errors;

  nes_clk_reset_gen #(
    .LOCK_STABLE_CYCLES(LSC),
    .CPU_DIV(CPD),
    .PPU_DIV(PPD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .pll_lock(pll_lock),
`ifdef NES_CLK_PAUSE_EN
    .pause(pause),
    .pause_ack(pause_ack),
`endif
    .sys_resetn(sys_resetn),
    .cpu_ce(cpu_ce),
    .ppu_ce(ppu_ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    pll_lock = 1'b1;
    repeat (3) step();
    checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL reset_sys_resetn got %b want 0", sys_resetn); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce got %b want 0", cpu_ce); end
    checks++; if (ppu_ce !== 1'b0) begin errors++; $display("FAIL reset_ppu_ce got %b want 0", ppu_ce); end
`ifdef NES_CLK_PAUSE_EN
    checks++; if (pause_ack !== 1'b0) begin errors++; $display("FAIL reset_pause_ack got %b want 0", pause_ack); end
`endif
    resetn = 1'b1;
    // Edge n = n-th edge with resetn high; the release lands on edge LSC+3.
    for (int n = 1; n <= LSC + 3; n++) begin
      step();
      if (n == LSC + 2) begin
        checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL qual_early got %b want 0 at edge %0d", sys_resetn, n); end
      end
      if (n == LSC + 3) begin
        checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL qual_release got %b want 1 at edge %0d", sys_resetn, n); end
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL ce_at_T got %b want 0", cpu_ce); end
      end
    end
  endtask

  task automatic test_free_run();
    int cpu_cnt;
    int ppu_cnt;
    logic exp_cpu;
    logic exp_ppu;
    cpu_cnt = 0;
    ppu_cnt = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      exp_cpu = ((k - 1) % CPD) == 0;
      exp_ppu = ((k - 1) % PPD) == 0;
      if (cpu_ce === 1'b1) cpu_cnt++;
      if (ppu_ce === 1'b1) ppu_cnt++;
      checks++; if (cpu_ce !== exp_cpu) begin errors++; $display("FAIL run_cpu_ce T+%0d got %b want %b", k, cpu_ce, exp_cpu); end
      checks++; if (ppu_ce !== exp_ppu) begin errors++; $display("FAIL run_ppu_ce T+%0d got %b want %b", k, ppu_ce, exp_ppu); end
      checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL run_sys_resetn T+%0d got %b want 1", k, sys_resetn); end
    end
    checks++; if (cpu_cnt != 10) begin errors++; $display("FAIL run_cpu_count got %0d want 10", cpu_cnt); end
    checks++; if (ppu_cnt != 30) begin errors++; $display("FAIL run_ppu_count got %0d want 30", ppu_cnt); end
  endtask

  task automatic test_stable_drop();
    // The stable counter reads 500 after edge 503; lock_s is low for exactly one cycle (edge 506).
    localparam int DROP = 503;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int n = 1; n <= DROP + LSC + 4; n++) begin
      step();
      if (n == DROP) pll_lock = 1'b0;
      if (n == DROP + 1) pll_lock = 1'b1;
      if (n == LSC + 3) begin
        checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL drop_no_early_release got %b want 0", sys_resetn); end
      end
      if (n == DROP + LSC + 3) begin
        checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL drop_release_early got %b want 0", sys_resetn); end
      end
      if (n == DROP + LSC + 4) begin
        checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL drop_release got %b want 1", sys_resetn); end
      end
    end
  endtask

  task automatic test_run_lock_drop();
    repeat (5) step();
    pll_lock = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 2) begin
        checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL lockloss_sync_delay got %b want 1", sys_resetn); end
      end
      if (n >= 3) begin
        checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL lockloss_sys_resetn edge %0d got %b want 0", n, sys_resetn); end
        checks++; if ({cpu_ce, ppu_ce} !== 2'b00) begin errors++; $display("FAIL lockloss_ce edge %0d got %b want 00", n, {cpu_ce, ppu_ce}); end
      end
    end
    pll_lock = 1'b1;
    for (int n = 1; n <= LSC + 4; n++) begin
      step();
      if (n == LSC + 2) begin
        checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", sys_resetn); end
      end
      if (n == LSC + 3) begin
        checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL relock_release got %b want 1", sys_resetn); end
      end
      if (n == LSC + 4) begin
        checks++; if ({cpu_ce, ppu_ce} !== 2'b11) begin errors++; $display("FAIL relock_first_ce got %b want 11", {cpu_ce, ppu_ce}); end
      end
    end
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    while (cpu_ce !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL async_setup_cpu_ce got %b want 1", cpu_ce); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (sys_resetn !== 1'b0) begin errors++; $display("FAIL async_sys_resetn got %b want 0", sys_resetn); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL async_cpu_ce got %b want 0", cpu_ce); end
    checks++; if (ppu_ce !== 1'b0) begin errors++; $display("FAIL async_ppu_ce got %b want 0", ppu_ce); end
    repeat (2) step();
    checks++; if ({sys_resetn, cpu_ce, ppu_ce} !== 3'b000) begin errors++; $display("FAIL async_hold got %b want 000", {sys_resetn, cpu_ce, ppu_ce}); end
    resetn = 1'b1;
  endtask

`ifdef NES_CLK_PAUSE_EN
  task automatic test_pause();
    int waited;
    waited = 0;
    while (sys_resetn !== 1'b1 && waited < LSC + 20) begin
      step();
      waited++;
    end
    checks++; if (sys_resetn !== 1'b1) begin errors++; $display("FAIL pause_setup_release got %b want 1", sys_resetn); end
    // T is the current edge; phase after edge T+k is k mod CPU_DIV until the freeze.
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) begin
        checks++; if ({cpu_ce, ppu_ce} !== 2'b11) begin errors++; $display("FAIL pause_first_ce got %b want 11", {cpu_ce, ppu_ce}); end
      end
      if (k == 9) begin
        checks++; if ({cpu_ce, ppu_ce, pause_ack} !== 3'b010) begin errors++; $display("FAIL pause_ppu_phase8 got %b want 010", {cpu_ce, ppu_ce, pause_ack}); end
      end
      if (k == 11) begin
        checks++; if (pause_ack !== 1'b0) begin errors++; $display("FAIL pause_ack_early got %b want 0", pause_ack); end
      end
      if (k >= 12 && k <= 20) begin
        checks++; if ({cpu_ce, ppu_ce, pause_ack} !== 3'b001) begin errors++; $display("FAIL pause_frozen T+%0d got %b want 001", k, {cpu_ce, ppu_ce, pause_ack}); end
      end
      if (k == 21) begin
        checks++; if ({cpu_ce, ppu_ce, pause_ack} !== 3'b000) begin errors++; $display("FAIL pause_ack_drop got %b want 000", {cpu_ce, ppu_ce, pause_ack}); end
      end
      if (k == 22) begin
        checks++; if ({cpu_ce, ppu_ce} !== 2'b11) begin errors++; $display("FAIL pause_resume_ce got %b want 11", {cpu_ce, ppu_ce}); end
      end
      if (k == 26) begin
        checks++; if ({cpu_ce, ppu_ce} !== 2'b01) begin errors++; $display("FAIL pause_resume_ppu got %b want 01", {cpu_ce, ppu_ce}); end
      end
      if (k == 40) begin
        checks++; if (pause_ack !== 1'b1) begin errors++; $display("FAIL pause_refreeze got %b want 1", pause_ack); end
      end
      if (k == 5) pause = 1'b1;
      if (k == 20) pause = 1'b0;
      if (k == 27) pause = 1'b1;
    end
    pll_lock = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      if (n == 2) begin
        checks++; if (pause_ack !== 1'b1) begin errors++; $display("FAIL pause_lockloss_hold got %b want 1", pause_ack); end
      end
      if (n == 3) begin
        checks++; if ({sys_resetn, pause_ack} !== 2'b00) begin errors++; $display("FAIL pause_lockloss got %b want 00", {sys_resetn, pause_ack}); end
      end
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    resetn   = 1'b0;
    pll_lock = 1'b0;
`ifdef NES_CLK_PAUSE_EN
    pause    = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_stable_drop();
    test_run_lock_drop();
    test_async_reset();
`ifdef NES_CLK_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_clk_reset_gen.md
NES_CLK_RESET_GEN -- requirements
Module: nes_clk_reset_gen

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, meaning the number of consecutive clk cycles the synchronised PLL lock must stay high before system reset release.
REQ-002 The block SHALL have parameter CPU_DIV, default 12, meaning the clk cycles per cpu_ce pulse.
REQ-003 The block SHALL have parameter PPU_DIV, default 4, meaning the clk cycles per ppu_ce pulse; CPU_DIV SHALL be an integer multiple of PPU_DIV.
REQ-004 The block SHALL have port clk, input, 1 bit: the 21.6 MHz PLL divided output and the only clock.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-007 The block SHALL have port sys_resetn, output, 1 bit: synchronous active-low reset for the NES core.
REQ-008 The block SHALL have port cpu_ce, output, 1 bit: one-cycle CPU clock enable.
REQ-009 The block SHALL have port ppu_ce, output, 1 bit: one-cycle PPU clock enable.
REQ-010 The block SHALL have port pause, input, 1 bit: pause request (present only with PAUSE_EN).
REQ-011 The block SHALL have port pause_ack, output, 1 bit: core frozen (present only with PAUSE_EN).

Function
REQ-012 The block SHALL pass pll_lock through a 2-flop synchroniser; lock_s SHALL denote its output, with 2 cycles of latency.
REQ-013 The block SHALL implement the state machine states S_WAIT_LOCK, S_STABLE and S_RUN.
REQ-014 In S_WAIT_LOCK, the block SHALL go to S_STABLE with the stable counter cleared when lock_s=1.
REQ-015 In S_STABLE, the stable counter SHALL increment each cycle that lock_s=1, and the block SHALL go to S_RUN when the count reaches LOCK_STABLE_CYCLES-1.
REQ-016 In any state, lock_s=0 SHALL force S_WAIT_LOCK on the next cycle, clear the stable counter, drive sys_resetn=0 and drive cpu_ce=ppu_ce=0 from that cycle.
REQ-017 sys_resetn SHALL be registered and equal 1 only while in S_RUN; the first S_RUN cycle is cycle T.
REQ-018 The phase counter SHALL be 0 at cycle T, count 0..CPU_DIV-1 and wrap to 0, and be held at 0 outside S_RUN.
REQ-019 cpu_ce and ppu_ce SHALL be registered outputs.
REQ-020 cpu_ce SHALL be 1 on the cycle after the phase counter equals 0; the first cpu_ce SHALL be at T+1 and repeat every CPU_DIV cycles.
REQ-021 ppu_ce SHALL be 1 on the cycle after the phase counter mod PPU_DIV equals 0; ppu_ce SHALL be coincident with every cpu_ce (3 ppu_ce per cpu_ce with defaults).
REQ-022 cpu_ce and ppu_ce SHALL never be high while sys_resetn=0.
REQ-023 Counter widths SHALL be clog2 of the respective terminal value, and no counter SHALL wrap except the phase counter.

Reset
REQ-024 While resetn=0 the block SHALL asynchronously hold: state=S_WAIT_LOCK, both synchroniser flops=0, all counters=0, sys_resetn=0, cpu_ce=0, ppu_ce=0, pause_ack=0.
REQ-025 Reset deassertion SHALL take effect at the next clk edge with no further hold-off beyond lock qualification.
REQ-026 Reset asserted mid-count or mid-run SHALL restart the full lock qualification.

Configuration
REQ-027 The block SHALL be controlled by macro NES_CLK_PAUSE_EN.
REQ-028 With NES_CLK_PAUSE_EN defined, the pause and pause_ack ports SHALL exist.
REQ-029 With NES_CLK_PAUSE_EN defined, pause=1 in S_RUN SHALL freeze the phase counter when it would wrap to 0, so no cpu_ce or ppu_ce issues; pause_ack SHALL go to 1 on that same cycle.
REQ-030 With NES_CLK_PAUSE_EN defined, pause=0 while frozen SHALL drop pause_ack next cycle, and the cycle after that SHALL give cpu_ce=ppu_ce=1, resuming the normal pattern.
REQ-031 With NES_CLK_PAUSE_EN defined, lock loss during pause SHALL clear pause_ack and follow REQ-016.
REQ-032 Without NES_CLK_PAUSE_EN, the pause and pause_ack ports SHALL be absent and the phase counter SHALL run freely in S_RUN.

Verification
REQ-033 Bench SHALL drive resetn low then high with pll_lock=1 held -> sys_resetn rises exactly 2+LOCK_STABLE_CYCLES+1 cycles after the first clk edge with resetn high (synchroniser plus qualification, per RTL count); first cpu_ce/ppu_ce at T+1.
REQ-034 Bench SHALL run free in S_RUN for 120 cycles -> exactly 10 cpu_ce and 30 ppu_ce, each one cycle wide, cpu_ce always coincident with ppu_ce.
REQ-035 Bench SHALL drop pll_lock for 1 cycle at count 500 in S_STABLE -> counter restarts; sys_resetn release delayed by a full LOCK_STABLE_CYCLES from lock_s returning high.
REQ-036 Bench SHALL drop pll_lock in S_RUN -> sys_resetn=0 and CEs=0 within 3 cycles of the pll_lock edge; re-lock -> full qualification repeats.
REQ-037 Bench SHALL assert resetn=0 asynchronously between clk edges in S_RUN -> all outputs 0 immediately, without waiting for a clk edge.
REQ-038 Bench with NES_CLK_PAUSE_EN defined SHALL assert pause at phase 5 -> ppu_ce at phase 8, then pause_ack=1 with no CEs; pause=0 -> cpu_ce=ppu_ce=1 two cycles later.
